score_topk_extractor: RTL and testbench
=======================================

Name: score_topk_extractor

Overview:
- Downstream consumer of the random-walk/score stage.
- After the score table in BRAM has been finalised (scores divided by node degree), this block scans score entries for nodes 1..node_num and keeps a sorted top-K list of (node, score) in registers.
- It then streams the list out, highest score first, over a valid/ready interface to the PS-side readout logic.
- It owns the BRAM read port only while busy. Arbitration with the walk stage is external.

Parameters:
- ADDR_WIDTH, 13: BRAM address width.
- DATA_WIDTH, 32: BRAM word / score width. Scores are unsigned.
- score_table_offset, 1000: BRAM address of the score table base. The score of node n is at score_table_offset + n.
- node_num, 100: nodes are numbered 1..node_num.
- TOP_K, 8: number of ranked entries kept and emitted. Legal range is 1..16.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a scan. Ignored unless idle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last entry is accepted.
- bram_addr  out  ADDR_WIDTH  score-table read address.
- bram_rd_en  out  1  read strobe. The BRAM returns data exactly one cycle later.
- bram_rdata  in  DATA_WIDTH  BRAM read data.
- out_valid  out  1  ranked entry available.
- out_ready  in  1  consumer accepts the entry when out_valid && out_ready.
- out_node  out  DATA_WIDTH  node id of the entry.
- out_score  out  DATA_WIDTH  score of the entry.
- out_rank  out  4  rank, 0 = highest.

Behaviour:
- Reset (async, any state) drives: state=IDLE; busy, done, bram_rd_en, out_valid = 0; bram_addr, out_node, out_score, out_rank = 0; all top-K slots invalid; counters = 0.
- A scan in progress is abandoned on reset, with no partial output. Reset release is internally synchronised.
- FSM states and transitions:
  - IDLE: start=1 -> SCAN. Load node counter = 1.
  - SCAN: every cycle drive bram_rd_en=1 and bram_addr = score_table_offset + node counter, then increment the counter. After issuing node_num, go to DRAIN.
  - DRAIN: one cycle, bram_rd_en=0. The final returned word is inserted here. Then go to EMIT with rank=0.
  - EMIT: present slot[rank] with out_valid=1, holding all outputs stable until accepted.
    - On accept, rank increments.
    - After rank = min(TOP_K, node_num)-1 is accepted, go to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Read pipeline: the node id issued in cycle t is delayed one cycle alongside the read. In cycle t+1, bram_rdata is paired with that id and inserted the same cycle. Throughput is one node per cycle.
- Total time from start to first out_valid is node_num+2 cycles.
- Insertion is a single-cycle parallel compare-and-shift:
  - A new entry goes into the first slot that is invalid or holds a strictly smaller score.
  - Lower slots shift down by one, and slot TOP_K-1 drops off.
- Ties: an equal score does not displace an existing entry, so the lower node id ranks higher.
- Zero scores are legal entries and fill empty slots.
- If node_num < TOP_K, only node_num entries are emitted. Invalid slots are never emitted.
- start during busy or DONE is ignored, with no queueing.
- out_ready held high means one entry per cycle. out_ready low stalls indefinitely, with no data loss.
- Address arithmetic is computed at DATA_WIDTH and truncated to ADDR_WIDTH. score_table_offset + node_num must be < 2^ADDR_WIDTH; this is checked by an elaboration assertion.
- In IDLE, EMIT and DONE, bram_rd_en=0 and bram_addr holds its last value.

Test Plan:
- Default parameters, BRAM score(n)=n for n=1..100, start pulse, out_ready=1 -> first out_valid at cycle 102 after start; emitted nodes 100,99,...,93 with scores equal to node ids and ranks 0..7; done pulses once, one cycle after the rank-7 accept.
- Scores all 0 except score(37)=500, score(5)=500, score(90)=7 -> ranks: (5,500), (37,500), (90,7), then nodes 1,2,3,4,6 with score 0.
- node_num=3, TOP_K=8, scores {10,30,20} -> exactly 3 entries (2,30), (3,20), (1,10); then done.
- out_ready toggled 1,0,0,1,... during EMIT -> out_node/out_score/out_rank stable while stalled; no entry duplicated or skipped.
- rst asserted at scan cycle 50, released, start reissued -> no out_valid from the aborted scan; second scan output equals the clean-run result.
- start pulsed again while busy and during DONE -> ignored; exactly one done pulse per accepted start.

Source files
------------

// File: rtl/score_topk_extractor.sv
// Scans the finalised score table for nodes 1..node_num, keeps a sorted top-K list
// of (node, score) in registers, then streams it out highest score first.
module score_topk_extractor #(
   parameter int unsigned ADDR_WIDTH         = 13,
   parameter int unsigned DATA_WIDTH         = 32,
   parameter int unsigned score_table_offset = 1000,
   parameter int unsigned node_num           = 100,
   parameter int unsigned TOP_K              = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic                  bram_rd_en,
   input  logic [DATA_WIDTH-1:0] bram_rdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_node,
   output logic [DATA_WIDTH-1:0] out_score,
   output logic [3:0]            out_rank
);

   localparam int unsigned NUM_EMIT = (TOP_K < node_num) ? TOP_K : node_num;
   localparam logic [3:0] LAST_RANK = 4'(NUM_EMIT - 1);
   localparam logic [DATA_WIDTH-1:0] NODE_LAST  = DATA_WIDTH'(node_num);
   localparam logic [DATA_WIDTH-1:0] TABLE_BASE = DATA_WIDTH'(score_table_offset);

   if (TOP_K < 1 || TOP_K > 16) begin : g_topk_range
      $fatal(1, "score_topk_extractor: TOP_K must be in 1..16");
   end
   if (node_num < 1) begin : g_node_num_range
      $fatal(1, "score_topk_extractor: node_num must be at least 1");
   end
   if ((64'(score_table_offset) + 64'(node_num)) >= (64'd1 << ADDR_WIDTH)) begin : g_addr_range
      $fatal(1, "score_topk_extractor: score table does not fit in ADDR_WIDTH");
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DRAIN,
      ST_EMIT,
      ST_DONE
   } state_t;

   // Asynchronous assert, synchronous release of the internal reset
   logic [1:0] rst_pipe;
   logic       rst_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rst_pipe <= 2'b11;
      else     rst_pipe <= {rst_pipe[0], 1'b0};
   end

   assign rst_i = rst_pipe[1];

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   node_cnt_q, node_cnt_d;
   logic                    busy_d, done_d, rd_en_d, out_valid_d, clear_slots;
   logic [ADDR_WIDTH-1:0]   addr_d;
   logic [DATA_WIDTH-1:0]   out_node_d, out_score_d;
   logic [3:0]              rank_d;

   logic                    rd_vld_q;
   logic [DATA_WIDTH-1:0]   rd_node_q;

   logic                    slot_vld_q   [TOP_K];
   logic [DATA_WIDTH-1:0]   slot_node_q  [TOP_K];
   logic [DATA_WIDTH-1:0]   slot_score_q [TOP_K];
   logic                    ins_vld      [TOP_K];
   logic [DATA_WIDTH-1:0]   ins_node     [TOP_K];
   logic [DATA_WIDTH-1:0]   ins_score    [TOP_K];

   logic [DATA_WIDTH-1:0]   cur_node, cur_score, nxt_node, nxt_score;

   // Slot selection for the entry being presented and the one after it
   always_comb begin
      cur_node  = '0;
      cur_score = '0;
      nxt_node  = '0;
      nxt_score = '0;
      for (int i = 0; i < TOP_K; i++) begin
         if (4'(i) == out_rank) begin
            cur_node  = slot_node_q[i];
            cur_score = slot_score_q[i];
         end
         if (4'(i) == out_rank + 4'd1) begin
            nxt_node  = slot_node_q[i];
            nxt_score = slot_score_q[i];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      node_cnt_d  = node_cnt_q;
      busy_d      = busy;
      done_d      = 1'b0;
      rd_en_d     = 1'b0;
      addr_d      = bram_addr;
      out_valid_d = out_valid;
      out_node_d  = out_node;
      out_score_d = out_score;
      rank_d      = out_rank;
      clear_slots = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_SCAN;
               busy_d      = 1'b1;
               node_cnt_d  = DATA_WIDTH'(1);
               rd_en_d     = 1'b1;
               addr_d      = ADDR_WIDTH'(TABLE_BASE + DATA_WIDTH'(1));
               clear_slots = 1'b1;
            end
         end
         ST_SCAN: begin
            if (node_cnt_q == NODE_LAST) begin
               state_d = ST_DRAIN;
            end else begin
               node_cnt_d = node_cnt_q + DATA_WIDTH'(1);
               rd_en_d    = 1'b1;
               addr_d     = ADDR_WIDTH'(TABLE_BASE + node_cnt_d);
            end
         end
         ST_DRAIN: begin
            state_d = ST_EMIT;
            rank_d  = 4'd0;
         end
         ST_EMIT: begin
            // First EMIT cycle loads rank 0 after the final insertion has settled
            if (!out_valid) begin
               out_valid_d = 1'b1;
               out_node_d  = cur_node;
               out_score_d = cur_score;
            end else if (out_ready) begin
               if (out_rank == LAST_RANK) begin
                  state_d     = ST_DONE;
                  out_valid_d = 1'b0;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
               end else begin
                  rank_d      = out_rank + 4'd1;
                  out_node_d  = nxt_node;
                  out_score_d = nxt_score;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         node_cnt_q <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         bram_rd_en <= 1'b0;
         bram_addr  <= '0;
         out_valid  <= 1'b0;
         out_node   <= '0;
         out_score  <= '0;
         out_rank   <= '0;
      end else begin
         state_q    <= state_d;
         node_cnt_q <= node_cnt_d;
         busy       <= busy_d;
         done       <= done_d;
         bram_rd_en <= rd_en_d;
         bram_addr  <= addr_d;
         out_valid  <= out_valid_d;
         out_node   <= out_node_d;
         out_score  <= out_score_d;
         out_rank   <= rank_d;
      end
   end

   // Node id travels one cycle behind the read so it meets its returned score
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         rd_vld_q  <= 1'b0;
         rd_node_q <= '0;
      end else begin
         rd_vld_q  <= bram_rd_en;
         rd_node_q <= node_cnt_q;
      end
   end

   // Valid slots stay contiguous and sorted, so the take condition is monotone in i
   always_comb begin
      logic                  take_i;
      logic                  carry;
      logic                  prev_vld;
      logic [DATA_WIDTH-1:0] prev_node, prev_score;
      take_i     = 1'b0;
      carry      = 1'b0;
      prev_vld   = 1'b0;
      prev_node  = '0;
      prev_score = '0;
      for (int i = 0; i < TOP_K; i++) begin
         take_i       = !slot_vld_q[i] || (slot_score_q[i] < bram_rdata);
         ins_vld[i]   = slot_vld_q[i];
         ins_node[i]  = slot_node_q[i];
         ins_score[i] = slot_score_q[i];
         if (take_i) begin
            if (carry) begin
               ins_vld[i]   = prev_vld;
               ins_node[i]  = prev_node;
               ins_score[i] = prev_score;
            end else begin
               ins_vld[i]   = 1'b1;
               ins_node[i]  = rd_node_q;
               ins_score[i] = bram_rdata;
            end
         end
         carry      = take_i;
         prev_vld   = slot_vld_q[i];
         prev_node  = slot_node_q[i];
         prev_score = slot_score_q[i];
      end
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < TOP_K; i++) begin
            slot_vld_q[i]   <= 1'b0;
            slot_node_q[i]  <= '0;
            slot_score_q[i] <= '0;
         end
      end else if (clear_slots) begin
         for (int i = 0; i < TOP_K; i++) begin
            slot_vld_q[i] <= 1'b0;
         end
      end else if (rd_vld_q) begin
         for (int i = 0; i < TOP_K; i++) begin
            slot_vld_q[i]   <= ins_vld[i];
            slot_node_q[i]  <= ins_node[i];
            slot_score_q[i] <= ins_score[i];
         end
      end
   end

endmodule

// File: tb/tb_score_topk_extractor.sv
// Scoreboard bench for score_topk_extractor: a 100-node/top-8 instance and a 3-node instance.
module tb_score_topk_extractor;

   localparam int unsigned AW   = 13;
   localparam int unsigned DW   = 32;
   localparam int unsigned OFFS = 1000;

   typedef struct {
      logic [31:0] node;
      logic [31:0] score;
      int          rank;
   } ent_t;

   logic step_clk = 1'b0;
   logic rst;
   always #5 step_clk = ~step_clk;

   logic          start_a, busy_a, done_a, rden_a, ov_a, ordy_a;
   logic [AW-1:0] addr_a;
   logic [DW-1:0] rdata_a, onode_a, oscore_a;
   logic [3:0]    orank_a;
   logic          start_b, busy_b, done_b, rden_b, ov_b, ordy_b;
   logic [AW-1:0] addr_b;
   logic [DW-1:0] rdata_b, onode_b, oscore_b;
   logic [3:0]    orank_b;

   score_topk_extractor #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .score_table_offset(OFFS),
                          .node_num(100), .TOP_K(8)) dut_a (
      .clk(step_clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
      .bram_addr(addr_a), .bram_rd_en(rden_a), .bram_rdata(rdata_a),
      .out_valid(ov_a), .out_ready(ordy_a), .out_node(onode_a), .out_score(oscore_a),
      .out_rank(orank_a));

   score_topk_extractor #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .score_table_offset(OFFS),
                          .node_num(3), .TOP_K(8)) dut_b (
      .clk(step_clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
      .bram_addr(addr_b), .bram_rd_en(rden_b), .bram_rdata(rdata_b),
      .out_valid(ov_b), .out_ready(ordy_b), .out_node(onode_b), .out_score(oscore_b),
      .out_rank(orank_b));

   // BRAM models: one-cycle read latency, sentinel values outside the table
   logic [31:0] mem_a [0:127];
   logic [31:0] mem_b [0:127];
   int ia_a, ia_b;
   assign ia_a = int'(addr_a) - int'(OFFS);
   assign ia_b = int'(addr_b) - int'(OFFS);

   always @(posedge step_clk) begin
      if (rden_a) rdata_a <= (ia_a >= 0 && ia_a < 128) ? mem_a[ia_a] : 32'hDEAD_BEEF;
      if (rden_b) rdata_b <= (ia_b >= 0 && ia_b < 128) ? mem_b[ia_b] : 32'hDEAD_BEEF;
   end

   int   n_checks = 0;
   int   n_fail   = 0;
   ent_t exp_q[$];
   ent_t got_q[$];
   ent_t e, g;

   int   c_first, c_done_cyc, c_last_acc, c_done_cnt;
   logic c_timeout, c_stall_bad;

   task automatic fill_sentinel();
      for (int i = 0; i < 128; i++) begin
         mem_a[i] = 32'hFFFF_FFF0;
         mem_b[i] = 32'hFFFF_FFF0;
      end
   endtask

   task automatic pulse_start(input bit sel_b);
      @(posedge step_clk); #1;
      if (sel_b) start_b = 1'b1; else start_a = 1'b1;
      @(posedge step_clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   // Records accepted entries and timing; mode 0 ready high, 1 ready 1,0,0,1, 2 start spam
   task automatic collect(input bit sel_b, input int mode, input int max_cyc);
      logic        v, d, rdy, pv, pr;
      logic [31:0] nd, sc, pn, ps;
      logic [3:0]  rk, prk;
      got_q.delete();
      c_first = -1; c_done_cyc = -1; c_last_acc = -1; c_done_cnt = 0;
      c_timeout = 1'b1; c_stall_bad = 1'b0;
      pv = 1'b0; pr = 1'b0; pn = '0; ps = '0; prk = '0;
      for (int cyc = 1; cyc <= max_cyc; cyc++) begin
         @(posedge step_clk); #1;
         start_a = 1'b0;
         start_b = 1'b0;
         v  = sel_b ? ov_b     : ov_a;
         d  = sel_b ? done_b   : done_a;
         nd = sel_b ? onode_b  : onode_a;
         sc = sel_b ? oscore_b : oscore_a;
         rk = sel_b ? orank_b  : orank_a;
         rdy = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         ordy_a = rdy;
         ordy_b = rdy;
         if (v && c_first < 0) c_first = cyc;
         if (pv && !pr && v && (nd !== pn || sc !== ps || rk !== prk)) c_stall_bad = 1'b1;
         if (v && rdy) begin
            got_q.push_back('{node: nd, score: sc, rank: int'(rk)});
            c_last_acc = cyc;
         end
         if (d) begin
            c_done_cnt++;
            if (c_done_cyc < 0) c_done_cyc = cyc;
         end
         if (mode == 2 && (cyc == 10 || cyc == 60 || cyc == 103 || d)) begin
            if (sel_b) start_b = 1'b1; else start_a = 1'b1;
         end
         pv = v; pr = rdy; pn = nd; ps = sc; prk = rk;
         if (c_done_cyc > 0 && cyc >= c_done_cyc + 4) begin
            c_timeout = 1'b0;
            break;
         end
      end
      start_a = 1'b0;
      start_b = 1'b0;
      ordy_a  = 1'b1;
      ordy_b  = 1'b1;
   endtask

   // Reference ranking: highest score first, lower node id wins ties
   task automatic build_expected(input bit sel_b, input int n, input int k);
      bit used [0:127];
      int best;
      int cnt;
      logic [31:0] s_best, s_i;
      exp_q.delete();
      for (int i = 0; i < 128; i++) used[i] = 1'b0;
      cnt = (n < k) ? n : k;
      for (int r = 0; r < cnt; r++) begin
         best = -1;
         s_best = '0;
         for (int i = 1; i <= n; i++) begin
            s_i = sel_b ? mem_b[i] : mem_a[i];
            if (!used[i] && (best < 0 || s_i > s_best)) begin
               best = i;
               s_best = s_i;
            end
         end
         used[best] = 1'b1;
         exp_q.push_back('{node: 32'(best), score: s_best, rank: r});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy_a); end
      repeat (3) @(posedge step_clk);
      #1 rst = 1'b0;
      repeat (4) @(posedge step_clk);
      #1;
      n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy_rel: got %b, required 0", busy_a); end
      n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", done_a); end
      n_checks++; if (rden_a !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b, required 0", rden_a); end
      n_checks++; if (ov_a !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", ov_a); end
      n_checks++; if (addr_a !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d, required 0", addr_a); end
      n_checks++; if (onode_a !== '0) begin n_fail++; $display("FAIL reset_out_node: got %0d, required 0", onode_a); end
      n_checks++; if (oscore_a !== '0) begin n_fail++; $display("FAIL reset_out_score: got %0d, required 0", oscore_a); end
      n_checks++; if (orank_a !== 4'd0) begin n_fail++; $display("FAIL reset_out_rank: got %0d, required 0", orank_a); end
      n_checks++; if (busy_b !== 1'b0 || ov_b !== 1'b0) begin n_fail++; $display("FAIL reset_b: got busy %b valid %b, required 0 0", busy_b, ov_b); end
   endtask

   task automatic test_ramp();
      fill_sentinel();
      for (int n = 1; n <= 100; n++) mem_a[n] = 32'(n);
      exp_q.delete();
      for (int r = 0; r < 8; r++) exp_q.push_back('{node: 32'(100 - r), score: 32'(100 - r), rank: r});
      pulse_start(1'b0);
      n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL ramp_busy: got %b, required 1", busy_a); end
      n_checks++; if (rden_a !== 1'b1) begin n_fail++; $display("FAIL ramp_rd_en: got %b, required 1", rden_a); end
      n_checks++; if (addr_a !== 13'd1001) begin n_fail++; $display("FAIL ramp_first_addr: got %0d, required 1001", addr_a); end
      collect(1'b0, 0, 400);
      n_checks++; if (c_timeout !== 1'b0) begin n_fail++; $display("FAIL ramp_timeout: got timeout %b, required 0", c_timeout); end
      n_checks++; if (c_first !== 102) begin n_fail++; $display("FAIL ramp_latency: got %0d, required 102", c_first); end
      n_checks++; if (c_done_cnt !== 1) begin n_fail++; $display("FAIL ramp_done_count: got %0d, required 1", c_done_cnt); end
      n_checks++; if (c_done_cyc !== c_last_acc + 1) begin n_fail++; $display("FAIL ramp_done_timing: got %0d, required %0d", c_done_cyc, c_last_acc + 1); end
      n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL ramp_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_checks++;
         if (got_q.size() == 0) begin n_fail++; $display("FAIL ramp_entry %0d: got none, required node %0d score %0d", e.rank, e.node, e.score); end
         else begin
            g = got_q.pop_front();
            if (g.node !== e.node || g.score !== e.score || g.rank !== e.rank) begin n_fail++;
               $display("FAIL ramp_entry %0d: got (%0d,%0d,r%0d), required (%0d,%0d,r%0d)", e.rank, g.node, g.score, g.rank, e.node, e.score, e.rank); end
         end
      end
   endtask

   task automatic test_ties();
      fill_sentinel();
      for (int n = 1; n <= 100; n++) mem_a[n] = 32'd0;
      mem_a[37] = 32'd500; mem_a[5] = 32'd500; mem_a[90] = 32'd7;
      exp_q.delete();
      exp_q.push_back('{node: 32'd5,  score: 32'd500, rank: 0});
      exp_q.push_back('{node: 32'd37, score: 32'd500, rank: 1});
      exp_q.push_back('{node: 32'd90, score: 32'd7,   rank: 2});
      exp_q.push_back('{node: 32'd1,  score: 32'd0,   rank: 3});
      exp_q.push_back('{node: 32'd2,  score: 32'd0,   rank: 4});
      exp_q.push_back('{node: 32'd3,  score: 32'd0,   rank: 5});
      exp_q.push_back('{node: 32'd4,  score: 32'd0,   rank: 6});
      exp_q.push_back('{node: 32'd6,  score: 32'd0,   rank: 7});
      pulse_start(1'b0);
      collect(1'b0, 0, 400);
      n_checks++; if (c_timeout !== 1'b0 || c_done_cnt !== 1) begin n_fail++; $display("FAIL ties_done: got timeout %b done %0d, required 0 1", c_timeout, c_done_cnt); end
      n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL ties_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_checks++;
         if (got_q.size() == 0) begin n_fail++; $display("FAIL ties_entry %0d: got none, required node %0d score %0d", e.rank, e.node, e.score); end
         else begin
            g = got_q.pop_front();
            if (g.node !== e.node || g.score !== e.score || g.rank !== e.rank) begin n_fail++;
               $display("FAIL ties_entry %0d: got (%0d,%0d,r%0d), required (%0d,%0d,r%0d)", e.rank, g.node, g.score, g.rank, e.node, e.score, e.rank); end
         end
      end
   endtask

   task automatic test_stall_random();
      fill_sentinel();
      for (int n = 1; n <= 100; n++) mem_a[n] = 32'($urandom_range(0, 20));
      build_expected(1'b0, 100, 8);
      pulse_start(1'b0);
      collect(1'b0, 1, 500);
      n_checks++; if (c_timeout !== 1'b0 || c_done_cnt !== 1) begin n_fail++; $display("FAIL stall_done: got timeout %b done %0d, required 0 1", c_timeout, c_done_cnt); end
      n_checks++; if (c_stall_bad !== 1'b0) begin n_fail++; $display("FAIL stall_hold: got outputs changed %b, required 0", c_stall_bad); end
      n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL stall_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_checks++;
         if (got_q.size() == 0) begin n_fail++; $display("FAIL stall_entry %0d: got none, required node %0d score %0d", e.rank, e.node, e.score); end
         else begin
            g = got_q.pop_front();
            if (g.node !== e.node || g.score !== e.score || g.rank !== e.rank) begin n_fail++;
               $display("FAIL stall_entry %0d: got (%0d,%0d,r%0d), required (%0d,%0d,r%0d)", e.rank, g.node, g.score, g.rank, e.node, e.score, e.rank); end
         end
      end
   endtask

   task automatic test_small_n();
      fill_sentinel();
      mem_b[1] = 32'd10; mem_b[2] = 32'd30; mem_b[3] = 32'd20;
      exp_q.delete();
      exp_q.push_back('{node: 32'd2, score: 32'd30, rank: 0});
      exp_q.push_back('{node: 32'd3, score: 32'd20, rank: 1});
      exp_q.push_back('{node: 32'd1, score: 32'd10, rank: 2});
      pulse_start(1'b1);
      collect(1'b1, 0, 100);
      n_checks++; if (c_first !== 5) begin n_fail++; $display("FAIL small_latency: got %0d, required 5", c_first); end
      n_checks++; if (c_timeout !== 1'b0 || c_done_cnt !== 1) begin n_fail++; $display("FAIL small_done: got timeout %b done %0d, required 0 1", c_timeout, c_done_cnt); end
      n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL small_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_checks++;
         if (got_q.size() == 0) begin n_fail++; $display("FAIL small_entry %0d: got none, required node %0d score %0d", e.rank, e.node, e.score); end
         else begin
            g = got_q.pop_front();
            if (g.node !== e.node || g.score !== e.score || g.rank !== e.rank) begin n_fail++;
               $display("FAIL small_entry %0d: got (%0d,%0d,r%0d), required (%0d,%0d,r%0d)", e.rank, g.node, g.score, g.rank, e.node, e.score, e.rank); end
         end
      end
   endtask

   task automatic test_abort_reset();
      logic leaked;
      fill_sentinel();
      for (int n = 1; n <= 100; n++) mem_a[n] = 32'(n);
      pulse_start(1'b0);
      repeat (49) @(posedge step_clk);
      #3 rst = 1'b1;
      #1;
      n_checks++; if (busy_a !== 1'b0 || rden_a !== 1'b0 || ov_a !== 1'b0) begin n_fail++;
         $display("FAIL abort_async: got busy %b rd_en %b valid %b, required 0 0 0", busy_a, rden_a, ov_a); end
      repeat (2) @(posedge step_clk);
      #1 rst = 1'b0;
      leaked = 1'b0;
      for (int cyc = 0; cyc < 130; cyc++) begin
         @(posedge step_clk); #1;
         if (ov_a || done_a || busy_a) leaked = 1'b1;
      end
      n_checks++; if (leaked !== 1'b0) begin n_fail++; $display("FAIL abort_leak: got activity %b, required 0", leaked); end
      exp_q.delete();
      for (int r = 0; r < 8; r++) exp_q.push_back('{node: 32'(100 - r), score: 32'(100 - r), rank: r});
      pulse_start(1'b0);
      collect(1'b0, 0, 400);
      n_checks++; if (c_timeout !== 1'b0 || c_done_cnt !== 1 || c_first !== 102) begin n_fail++;
         $display("FAIL abort_rerun: got timeout %b done %0d first %0d, required 0 1 102", c_timeout, c_done_cnt, c_first); end
      n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL abort_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_checks++;
         if (got_q.size() == 0) begin n_fail++; $display("FAIL abort_entry %0d: got none, required node %0d score %0d", e.rank, e.node, e.score); end
         else begin
            g = got_q.pop_front();
            if (g.node !== e.node || g.score !== e.score || g.rank !== e.rank) begin n_fail++;
               $display("FAIL abort_entry %0d: got (%0d,%0d,r%0d), required (%0d,%0d,r%0d)", e.rank, g.node, g.score, g.rank, e.node, e.score, e.rank); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic restarted;
      fill_sentinel();
      for (int n = 1; n <= 100; n++) mem_a[n] = 32'(101 - n);
      build_expected(1'b0, 100, 8);
      pulse_start(1'b0);
      collect(1'b0, 2, 400);
      n_checks++; if (c_timeout !== 1'b0 || c_done_cnt !== 1) begin n_fail++; $display("FAIL b2b_done: got timeout %b done %0d, required 0 1", c_timeout, c_done_cnt); end
      restarted = 1'b0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(posedge step_clk); #1;
         if (busy_a || rden_a) restarted = 1'b1;
      end
      n_checks++; if (restarted !== 1'b0) begin n_fail++; $display("FAIL b2b_queued_start: got restart %b, required 0", restarted); end
      n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_checks++;
         if (got_q.size() == 0) begin n_fail++; $display("FAIL b2b_entry %0d: got none, required node %0d score %0d", e.rank, e.node, e.score); end
         else begin
            g = got_q.pop_front();
            if (g.node !== e.node || g.score !== e.score || g.rank !== e.rank) begin n_fail++;
               $display("FAIL b2b_entry %0d: got (%0d,%0d,r%0d), required (%0d,%0d,r%0d)", e.rank, g.node, g.score, g.rank, e.node, e.score, e.rank); end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      start_a = 1'b0; start_b = 1'b0;
      ordy_a  = 1'b1; ordy_b  = 1'b1;
      rst     = 1'b1;
      fill_sentinel();
      test_reset();
      test_ramp();
      test_ties();
      test_stall_random();
      test_small_n();
      test_abort_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
